// File: rtl/sifive_insight_tl_echo_tracker_if.sv
// Monitor-tap bundle for the echo tracker: A/D beat taps in, trace record out.
interface sifive_insight_tl_echo_tracker_if #(
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned ECHO_W   = 8
);
  logic                a_fire;
  logic                a_first;
  logic [SOURCE_W-1:0] a_source;
  logic [ECHO_W-1:0]   a_echo;
  logic                d_fire;
  logic                d_last;
  logic [SOURCE_W-1:0] d_source;
  logic                t_valid;
  logic [SOURCE_W-1:0] t_source;
  logic [ECHO_W-1:0]   t_echo;
  logic                t_orphan;

  modport master (
    output a_fire, a_first, a_source, a_echo, d_fire, d_last, d_source,
    input  t_valid, t_source, t_echo, t_orphan
  );

  modport slave (
    input  a_fire, a_first, a_source, a_echo, d_fire, d_last, d_source,
    output t_valid, t_source, t_echo, t_orphan
  );
endinterface

// File: rtl/sifive_insight_tl_echo_tracker.sv
// Passive TileLink echo tracker: remembers the A-channel echo per source and
// replays it as a one-cycle-latency trace record on each matching D beat.
module sifive_insight_tl_echo_tracker #(
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned ECHO_W   = 8,
  parameter bit          DUP_OVWR = 1'b0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  sifive_insight_tl_echo_tracker_if.slave bus,
  input  logic                            err_clr,
  output logic [SOURCE_W:0]               outstanding,
  output logic                            err_dup,
  output logic                            err_orphan
);
  localparam int unsigned DEPTH = 2 ** SOURCE_W;
  localparam int unsigned CNT_W = SOURCE_W + 1;

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ECHO_W-1:0]   echo_q [DEPTH];
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                t_valid_q, t_valid_d;
  logic [SOURCE_W-1:0] t_source_q, t_source_d;
  logic [ECHO_W-1:0]   t_echo_q, t_echo_d;
  logic                t_orphan_q, t_orphan_d;
  logic                err_dup_q, err_dup_d;
  logic                err_orphan_q, err_orphan_d;

  logic alloc, a_hit, d_hit, free, same_src, a_busy, dup, new_alloc, echo_we, orphan;

  // All decisions use the pre-update table; a same-cycle free makes the A a fresh alloc.
  always_comb begin
    alloc     = bus.a_fire & bus.a_first;
    a_hit     = valid_q[bus.a_source];
    d_hit     = valid_q[bus.d_source];
    free      = bus.d_fire & bus.d_last & d_hit;
    same_src  = (bus.a_source == bus.d_source);
    a_busy    = a_hit & ~(free & same_src);
    dup       = alloc & a_busy;
    new_alloc = alloc & ~a_busy;
    echo_we   = new_alloc | (dup & DUP_OVWR);
    orphan    = bus.d_fire & ~d_hit;
  end

  always_comb begin
    valid_d       = valid_q;
    outstanding_d = outstanding_q;
    t_valid_d     = bus.d_fire;
    t_source_d    = t_source_q;
    t_echo_d      = t_echo_q;
    t_orphan_d    = t_orphan_q;
    err_dup_d     = err_dup_q;
    err_orphan_d  = err_orphan_q;

    if (free)      valid_d[bus.d_source] = 1'b0;
    if (new_alloc) valid_d[bus.a_source] = 1'b1;

    if (new_alloc && !free)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (free && !new_alloc) outstanding_d = outstanding_q - CNT_W'(1);

    if (bus.d_fire) begin
      t_source_d = bus.d_source;
      t_echo_d   = d_hit ? echo_q[bus.d_source] : '0;
      t_orphan_d = ~d_hit;
    end

    if (err_clr) begin
      err_dup_d    = 1'b0;
      err_orphan_d = 1'b0;
    end
    if (dup)    err_dup_d    = 1'b1;
    if (orphan) err_orphan_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q       <= '0;
      outstanding_q <= '0;
      t_valid_q     <= 1'b0;
      t_source_q    <= '0;
      t_echo_q      <= '0;
      t_orphan_q    <= 1'b0;
      err_dup_q     <= 1'b0;
      err_orphan_q  <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      outstanding_q <= outstanding_d;
      t_valid_q     <= t_valid_d;
      t_source_q    <= t_source_d;
      t_echo_q      <= t_echo_d;
      t_orphan_q    <= t_orphan_d;
      err_dup_q     <= err_dup_d;
      err_orphan_q  <= err_orphan_d;
    end
  end

  // Echo storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clock) begin
    if (echo_we) echo_q[bus.a_source] <= bus.a_echo;
  end

  assign bus.t_valid  = t_valid_q;
  assign bus.t_source = t_source_q;
  assign bus.t_echo   = t_echo_q;
  assign bus.t_orphan = t_orphan_q;
  assign outstanding  = outstanding_q;
  assign err_dup      = err_dup_q;
  assign err_orphan   = err_orphan_q;
endmodule

// File: tb/tb_sifive_insight_tl_echo_tracker.sv
// Directed bench for the TileLink echo tracker.
module tb_sifive_insight_tl_echo_tracker;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       err_clr;
  logic [4:0] outstanding;
  logic       err_dup;
  logic       err_orphan;
  int         checks = 0;
  int         fails  = 0;

  sifive_insight_tl_echo_tracker_if bus ();

  sifive_insight_tl_echo_tracker dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .err_clr(err_clr),
    .outstanding(outstanding), .err_dup(err_dup), .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic af, input logic afirst, input logic [3:0] asrc,
                       input logic [7:0] aecho, input logic df, input logic dlast,
                       input logic [3:0] dsrc, input logic clr);
    bus.a_fire = af; bus.a_first = afirst; bus.a_source = asrc; bus.a_echo = aecho;
    bus.d_fire = df; bus.d_last = dlast; bus.d_source = dsrc; err_clr = clr;
    @(posedge clock);
    #1;
    bus.a_fire = 1'b0; bus.a_first = 1'b0; bus.d_fire = 1'b0; bus.d_last = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; err_clr = 1'b0;
    bus.a_fire = 1'b0; bus.a_first = 1'b0; bus.a_source = '0; bus.a_echo = '0;
    bus.d_fire = 1'b0; bus.d_last = 1'b0; bus.d_source = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (outstanding !== 5'd0) begin fails++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if ({bus.t_valid, bus.t_orphan, bus.t_source, bus.t_echo} !== 14'd0) begin fails++; $display("FAIL reset_trace got=%b/%b/%h/%h exp=0", bus.t_valid, bus.t_orphan, bus.t_source, bus.t_echo); end
    checks++; if ({err_dup, err_orphan} !== 2'b00) begin fails++; $display("FAIL reset_err got=%b exp=00", {err_dup, err_orphan}); end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic;
    cycle(1, 1, 4'd3, 8'h5A, 0, 0, 4'd0, 0);
    checks++; if (outstanding !== 5'd1) begin fails++; $display("FAIL basic_out_alloc got=%0d exp=1", outstanding); end
    checks++; if (bus.t_valid !== 1'b0) begin fails++; $display("FAIL basic_no_trace got=%b exp=0", bus.t_valid); end
    cycle(0, 0, 4'd0, 8'h00, 1, 1, 4'd3, 0);
    checks++; if ({bus.t_valid, bus.t_source, bus.t_echo, bus.t_orphan} !== {1'b1, 4'd3, 8'h5A, 1'b0}) begin fails++; $display("FAIL basic_trace got=%b/%h/%h/%b exp=1/3/5a/0", bus.t_valid, bus.t_source, bus.t_echo, bus.t_orphan); end
    checks++; if (outstanding !== 5'd0) begin fails++; $display("FAIL basic_out_free got=%0d exp=0", outstanding); end
    cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 0);
    checks++; if ({bus.t_valid, bus.t_source, bus.t_echo} !== {1'b0, 4'd3, 8'h5A}) begin fails++; $display("FAIL basic_hold got=%b/%h/%h exp=0/3/5a", bus.t_valid, bus.t_source, bus.t_echo); end
  endtask

  task automatic test_multibeat;
    cycle(1, 1, 4'd2, 8'h11, 0, 0, 4'd0, 0);
    for (int b = 0; b < 3; b++) begin
      cycle(0, 0, 4'd0, 8'h00, 1, (b == 2), 4'd2, 0);
      checks++; if ({bus.t_valid, bus.t_echo, bus.t_orphan} !== {1'b1, 8'h11, 1'b0}) begin fails++; $display("FAIL multibeat_trace%0d got=%b/%h/%b exp=1/11/0", b, bus.t_valid, bus.t_echo, bus.t_orphan); end
      checks++; if (outstanding !== ((b == 2) ? 5'd0 : 5'd1)) begin fails++; $display("FAIL multibeat_out%0d got=%0d", b, outstanding); end
    end
  endtask

  task automatic test_orphan;
    cycle(0, 0, 4'd0, 8'h00, 1, 1, 4'd7, 0);
    checks++; if ({bus.t_valid, bus.t_source, bus.t_echo, bus.t_orphan} !== {1'b1, 4'd7, 8'h00, 1'b1}) begin fails++; $display("FAIL orphan_trace got=%b/%h/%h/%b exp=1/7/00/1", bus.t_valid, bus.t_source, bus.t_echo, bus.t_orphan); end
    checks++; if (err_orphan !== 1'b1) begin fails++; $display("FAIL orphan_flag got=%b exp=1", err_orphan); end
    cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 0);
    checks++; if (err_orphan !== 1'b1) begin fails++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
    cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 1);
    checks++; if (err_orphan !== 1'b0) begin fails++; $display("FAIL orphan_clr got=%b exp=0", err_orphan); end
    cycle(0, 0, 4'd0, 8'h00, 1, 1, 4'd7, 1);
    checks++; if (err_orphan !== 1'b1) begin fails++; $display("FAIL orphan_set_wins got=%b exp=1", err_orphan); end
    cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 1);
  endtask

  task automatic test_dup;
    cycle(1, 1, 4'd4, 8'h22, 0, 0, 4'd0, 0);
    cycle(1, 1, 4'd4, 8'h33, 0, 0, 4'd0, 0);
    checks++; if (err_dup !== 1'b1) begin fails++; $display("FAIL dup_flag got=%b exp=1", err_dup); end
    checks++; if (outstanding !== 5'd1) begin fails++; $display("FAIL dup_out got=%0d exp=1", outstanding); end
    cycle(0, 0, 4'd0, 8'h00, 1, 1, 4'd4, 0);
    checks++; if ({bus.t_echo, bus.t_orphan} !== {8'h22, 1'b0}) begin fails++; $display("FAIL dup_keep got=%h/%b exp=22/0", bus.t_echo, bus.t_orphan); end
    checks++; if (outstanding !== 5'd0) begin fails++; $display("FAIL dup_free got=%0d exp=0", outstanding); end
    cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 1);
    checks++; if (err_dup !== 1'b0) begin fails++; $display("FAIL dup_clr got=%b exp=0", err_dup); end
    cycle(1, 0, 4'd6, 8'h66, 0, 0, 4'd0, 0);
    checks++; if (outstanding !== 5'd0) begin fails++; $display("FAIL nonfirst_ignored got=%0d exp=0", outstanding); end
    cycle(0, 0, 4'd0, 8'h00, 1, 1, 4'd6, 0);
    checks++; if ({bus.t_echo, bus.t_orphan} !== {8'h00, 1'b1}) begin fails++; $display("FAIL nonfirst_orphan got=%h/%b exp=00/1", bus.t_echo, bus.t_orphan); end
    cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 1);
  endtask

  task automatic test_back_to_back;
    cycle(1, 1, 4'd5, 8'hAA, 0, 0, 4'd0, 0);
    cycle(1, 1, 4'd5, 8'hBB, 1, 1, 4'd5, 0);
    checks++; if ({bus.t_echo, bus.t_orphan} !== {8'hAA, 1'b0}) begin fails++; $display("FAIL same_src_old got=%h/%b exp=aa/0", bus.t_echo, bus.t_orphan); end
    checks++; if (outstanding !== 5'd1) begin fails++; $display("FAIL same_src_out got=%0d exp=1", outstanding); end
    cycle(0, 0, 4'd0, 8'h00, 1, 1, 4'd5, 0);
    checks++; if ({bus.t_echo, bus.t_orphan} !== {8'hBB, 1'b0}) begin fails++; $display("FAIL same_src_new got=%h/%b exp=bb/0", bus.t_echo, bus.t_orphan); end
    checks++; if (outstanding !== 5'd0) begin fails++; $display("FAIL same_src_free got=%0d exp=0", outstanding); end
    cycle(1, 1, 4'd8, 8'hC3, 0, 0, 4'd0, 0);
    cycle(1, 1, 4'd9, 8'h3C, 1, 1, 4'd8, 0);
    checks++; if ({bus.t_source, bus.t_echo} !== {4'd8, 8'hC3}) begin fails++; $display("FAIL diff_src_trace got=%h/%h exp=8/c3", bus.t_source, bus.t_echo); end
    checks++; if (outstanding !== 5'd1) begin fails++; $display("FAIL diff_src_out got=%0d exp=1", outstanding); end
    cycle(0, 0, 4'd0, 8'h00, 1, 1, 4'd9, 0);
    checks++; if ({bus.t_echo, outstanding} !== {8'h3C, 5'd0}) begin fails++; $display("FAIL diff_src_second got=%h/%0d exp=3c/0", bus.t_echo, outstanding); end
    cycle(1, 1, 4'd10, 8'h77, 1, 0, 4'd10, 0);
    checks++; if ({bus.t_orphan, bus.t_echo, outstanding} !== {1'b1, 8'h00, 5'd1}) begin fails++; $display("FAIL alloc_d_orphan got=%b/%h/%0d exp=1/00/1", bus.t_orphan, bus.t_echo, outstanding); end
    cycle(0, 0, 4'd0, 8'h00, 1, 1, 4'd10, 0);
    checks++; if ({bus.t_orphan, bus.t_echo, outstanding} !== {1'b0, 8'h77, 5'd0}) begin fails++; $display("FAIL alloc_d_follow got=%b/%h/%0d exp=0/77/0", bus.t_orphan, bus.t_echo, outstanding); end
    cycle(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 1);
  endtask

  task automatic test_fill_reset;
    for (int i = 0; i < 16; i++) cycle(1, 1, 4'(i), 8'(8'h40 + i), 0, 0, 4'd0, 0);
    checks++; if (outstanding !== 5'd16) begin fails++; $display("FAIL fill_out got=%0d exp=16", outstanding); end
    cycle(1, 1, 4'd12, 8'hEE, 1, 0, 4'd12, 0);
    checks++; if ({bus.t_echo, outstanding, err_dup} !== {8'h4C, 5'd16, 1'b1}) begin fails++; $display("FAIL fill_dup got=%h/%0d/%b exp=4c/16/1", bus.t_echo, outstanding, err_dup); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (outstanding !== 5'd0) begin fails++; $display("FAIL async_reset_out got=%0d exp=0", outstanding); end
    checks++; if ({bus.t_valid, bus.t_echo, err_dup} !== {1'b0, 8'h00, 1'b0}) begin fails++; $display("FAIL async_reset_trace got=%b/%h/%b exp=0/00/0", bus.t_valid, bus.t_echo, err_dup); end
    @(posedge clock); #1 reset_n = 1'b1;
    cycle(0, 0, 4'd0, 8'h00, 1, 1, 4'd0, 0);
    checks++; if ({bus.t_valid, bus.t_orphan, bus.t_echo, err_orphan} !== {1'b1, 1'b1, 8'h00, 1'b1}) begin fails++; $display("FAIL post_reset_orphan got=%b/%b/%h/%b exp=1/1/00/1", bus.t_valid, bus.t_orphan, bus.t_echo, err_orphan); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multibeat();
    test_orphan();
    test_dup();
    test_back_to_back();
    test_fill_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
